// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: depth derivation and head-stage state encoding.
package fifo_pkg;

  // Head stage: the memory rdata register acts as the output register.
  typedef enum logic {
    HeadEmpty = 1'b0,
    HeadValid = 1'b1
  } head_state_e;

  // Number of memory words addressable with addr_width bits.
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer with increment enable and synchronous load; MSB is the wrap bit.
module fifo_ptr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Load wins over increment; rollover is natural binary wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port memory whose registered
// read data serves as the output head stage.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AFULL_LVL  = 7,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned Depth = depth_of(ADDR_WIDTH);
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [CntW-1:0] DepthCnt  = CntW'(Depth);
  localparam logic [CntW-1:0] FullLvl   = CntW'(Depth + 1);
  localparam logic [CntW-1:0] AFullLvl  = CntW'(AFULL_LVL);
  localparam logic [CntW-1:0] AEmptyLvl = CntW'(AEMPTY_LVL);

  logic [CntW-1:0] wptr, rptr, mem_cnt;
  logic            push, pop;
  head_state_e     state_q, state_d;

  fifo_ptr #(
    .WIDTH (CntW)
  ) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (push),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wptr)
  );

  // Flush drops everything by snapping the read pointer onto the write pointer.
  fifo_ptr #(
    .WIDTH (CntW)
  ) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (mem_ren),
    .load     (flush),
    .load_val (wptr),
    .ptr      (rptr)
  );

  // Words committed to memory and not yet read out; the head word is counted separately.
  assign mem_cnt = wptr - rptr;

  // Handshakes and memory strobes, all from registered state.
  always_comb begin
    in_ready  = !flush && (mem_cnt != DepthCnt);
    push      = in_valid && in_ready;
    out_valid = (state_q == HeadValid);
    pop       = out_valid && out_ready;
    mem_ren   = !flush && (mem_cnt != '0) && (!out_valid || out_ready);
    mem_wen   = push;
    mem_wdata = in_data;
    mem_waddr = wptr[ADDR_WIDTH-1:0];
    mem_raddr = rptr[ADDR_WIDTH-1:0];
    out_data  = mem_rdata;
  end

  // Occupancy and status flags.
  always_comb begin
    level        = mem_cnt + CntW'(out_valid);
    full         = (level == FullLvl);
    empty        = (level == '0);
    almost_full  = (level >= AFullLvl);
    almost_empty = (level <= AEmptyLvl);
  end

  // Head-stage next state: a read fills the head, a pop without refill empties it.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = HeadEmpty;
    end else begin
      unique case (state_q)
        HeadEmpty: if (mem_ren) state_d = HeadValid;
        HeadValid: if (pop && !mem_ren) state_d = HeadEmpty;
      endcase
    end
  end

  // Head-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HeadEmpty;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
